// File: rtl/dw_dbp_apb_pkg.sv
// Shared definitions for the debug-APB completer: register offsets, STATUS
// bit positions, the default ID value and the transfer FSM state type.
package dw_dbp_apb_pkg;

   // Register byte offsets (bits [1:0] are ignored by the decoder)
   localparam logic [7:0] OFF_ID      = 8'h00;
   localparam logic [7:0] OFF_CTRL    = 8'h04;
   localparam logic [7:0] OFF_STATUS  = 8'h08;
   localparam logic [7:0] OFF_SCRATCH = 8'h0C;
   localparam logic [7:0] OFF_DATA    = 8'h10;
   localparam logic [7:0] OFF_ERRCNT  = 8'h14;

   // STATUS register bit positions
   localparam int ST_DBGEN   = 0;
   localparam int ST_NIDEN   = 1;
   localparam int ST_CNT_LSB = 8;
   localparam int ST_FULL    = 16;
   localparam int ST_EMPTY   = 17;

   localparam logic [31:0] ID_VAL_DEF = 32'h0DB0_0100;

   typedef enum logic [1:0] {IDLE, ACCESS, STALL} state_t;

endpackage

// File: rtl/dw_dbp_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. A push into a full
// FIFO and a pop from an empty FIFO are ignored; full/empty come from the
// registered count, so a same-cycle pop never frees room for a push.
module dw_dbp_sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage array; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dw_dbp_apb_completer.sv
// Debug-APB completer: decodes APB3 transfers into ID/CTRL/STATUS/SCRATCH/
// DATA registers, gates them by dbgen/niden and queues DATA writes into a
// FIFO drained over a valid/ready interface.
// Optional build macro DW_DBP_APB_ERRCNT_EN adds a saturating error counter
// at offset 0x14 (read to observe, any write clears).
module dw_dbp_apb_completer
   import dw_dbp_apb_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter int          DEPTH    = 4,
   parameter int          WAIT_MAX = 15,
   parameter logic [31:0] ID_VAL   = ID_VAL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_apb_dbgen,
   input  logic              dbg_apb_niden,
   input  logic              dbg_apb_psel,
   input  logic              dbg_apb_penable,
   input  logic              dbg_apb_pwrite,
   input  logic [ADDR_W-1:0] dbg_apb_paddr,
   input  logic [31:0]       dbg_apb_pwdata,
   output logic [31:0]       dbg_apb_prdata,
   output logic              dbg_apb_pready,
   output logic              dbg_apb_pslverr,
   output logic              cmd_valid,
   output logic [31:0]       cmd_data,
   input  logic              cmd_ready,
   output logic [31:0]       ctrl_q
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int SCW = $clog2(WAIT_MAX + 1);

   state_t            state;
   logic [31:0]       scratch;
   logic [31:0]       wdata_q;
   logic [SCW-1:0]    stall_cnt;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic              push, pop, setup;
   logic [31:0]       push_word;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       rd_val, status;
   logic              dec_err, wr_ctrl, wr_scratch, wr_data;
   logic              addr_unused;
`ifdef DW_DBP_APB_ERRCNT_EN
   logic [7:0]        errcnt;
   logic              wr_errcnt;
`endif

   // Byte-lane bits of the address carry no meaning for word registers
   assign addr_unused = ^dbg_apb_paddr[1:0];
   assign addr        = {dbg_apb_paddr[ADDR_W-1:2], 2'b00};
   assign setup       = (state == IDLE) & dbg_apb_psel & ~dbg_apb_penable;

   // STATUS snapshot built from live enables and registered FIFO state
   always_comb begin
      status                     = '0;
      status[ST_DBGEN]           = dbg_apb_dbgen;
      status[ST_NIDEN]           = dbg_apb_niden;
      status[ST_CNT_LSB +: 8]    = 8'(fifo_count);
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
   end

   // Setup-cycle decode: which register is hit and whether it errors
   always_comb begin
      rd_val     = '0;
      dec_err    = 1'b0;
      wr_ctrl    = 1'b0;
      wr_scratch = 1'b0;
      wr_data    = 1'b0;
`ifdef DW_DBP_APB_ERRCNT_EN
      wr_errcnt  = 1'b0;
`endif
      if (dbg_apb_pwrite) begin
         if (!dbg_apb_dbgen)                      dec_err    = 1'b1;
         else if (addr == ADDR_W'(OFF_CTRL))      wr_ctrl    = 1'b1;
         else if (addr == ADDR_W'(OFF_SCRATCH))   wr_scratch = 1'b1;
         else if (addr == ADDR_W'(OFF_DATA))      wr_data    = 1'b1;
`ifdef DW_DBP_APB_ERRCNT_EN
         else if (addr == ADDR_W'(OFF_ERRCNT))    wr_errcnt  = 1'b1;
`endif
         else                                     dec_err    = 1'b1;
      end else begin
         if (!dbg_apb_dbgen && !dbg_apb_niden)    dec_err    = 1'b1;
         else if (addr == ADDR_W'(OFF_ID))        rd_val     = ID_VAL;
         else if (addr == ADDR_W'(OFF_CTRL))      rd_val     = ctrl_q;
         else if (addr == ADDR_W'(OFF_STATUS))    rd_val     = status;
         else if (addr == ADDR_W'(OFF_SCRATCH))   rd_val     = scratch;
         else if (addr == ADDR_W'(OFF_DATA))      rd_val     = '0;
`ifdef DW_DBP_APB_ERRCNT_EN
         else if (addr == ADDR_W'(OFF_ERRCNT))    rd_val     = {24'd0, errcnt};
`endif
         else                                     dec_err    = 1'b1;
      end
   end

   // Push straight from the bus in setup, or the held word while stalling
   assign push      = (setup & wr_data & ~fifo_full) |
                      ((state == STALL) & dbg_apb_psel & ~fifo_full);
   assign push_word = (state == STALL) ? wdata_q : dbg_apb_pwdata;
   assign pop       = cmd_valid & cmd_ready;
   assign cmd_valid = ~fifo_empty;

   dw_dbp_sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .head      (cmd_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Transfer FSM with registered APB response and register commits
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dbg_apb_prdata  <= '0;
         dbg_apb_pready  <= 1'b0;
         dbg_apb_pslverr <= 1'b0;
         ctrl_q          <= '0;
         scratch         <= '0;
         wdata_q         <= '0;
         stall_cnt       <= '0;
`ifdef DW_DBP_APB_ERRCNT_EN
         errcnt          <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  // Only the word needs holding: STALL implies a DATA write
                  wdata_q <= dbg_apb_pwdata;
                  if (wr_ctrl)    ctrl_q  <= dbg_apb_pwdata;
                  if (wr_scratch) scratch <= dbg_apb_pwdata;
`ifdef DW_DBP_APB_ERRCNT_EN
                  if (wr_errcnt)  errcnt  <= '0;
                  if (dec_err && errcnt != 8'hFF) errcnt <= errcnt + 1'b1;
`endif
                  if (wr_data && fifo_full) begin
                     state          <= STALL;
                     stall_cnt      <= '0;
                     dbg_apb_pready <= 1'b0;
                  end else begin
                     state           <= ACCESS;
                     dbg_apb_pready  <= 1'b1;
                     dbg_apb_pslverr <= dec_err;
                     dbg_apb_prdata  <= dec_err ? '0 : rd_val;
                  end
               end
            end
            ACCESS: begin
               state           <= IDLE;
               dbg_apb_pready  <= 1'b0;
               dbg_apb_pslverr <= 1'b0;
               dbg_apb_prdata  <= '0;
            end
            STALL: begin
               if (!dbg_apb_psel) begin
                  // Requester abandoned the transfer; the word is dropped
                  state          <= IDLE;
                  dbg_apb_pready <= 1'b0;
               end else if (!fifo_full) begin
                  state           <= ACCESS;
                  dbg_apb_pready  <= 1'b1;
                  dbg_apb_pslverr <= 1'b0;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
                  // Give up in the cycle the counter reaches WAIT_MAX
                  if (stall_cnt == SCW'(WAIT_MAX - 1)) begin
                     state           <= ACCESS;
                     dbg_apb_pready  <= 1'b1;
                     dbg_apb_pslverr <= 1'b1;
`ifdef DW_DBP_APB_ERRCNT_EN
                     if (errcnt != 8'hFF) errcnt <= errcnt + 1'b1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dw_dbp_apb_completer.sv
// Directed bench for dw_dbp_apb_completer: register access, enable gating,
// FIFO fill/drain, full-FIFO stall timeout, stall release by a pop, and
// reset in the middle of a stall.
module tb_dw_dbp_apb_completer;

   logic        clk, rst;
   logic        dbgen, niden, psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_data, ctrl_q;

   int n_cmp = 0;
   int n_bad = 0;

   dw_dbp_apb_completer dut (
      .clk             (clk),
      .rst             (rst),
      .dbg_apb_dbgen   (dbgen),
      .dbg_apb_niden   (niden),
      .dbg_apb_psel    (psel),
      .dbg_apb_penable (penable),
      .dbg_apb_pwrite  (pwrite),
      .dbg_apb_paddr   (paddr),
      .dbg_apb_pwdata  (pwdata),
      .dbg_apb_prdata  (prdata),
      .dbg_apb_pready  (pready),
      .dbg_apb_pslverr (pslverr),
      .cmd_valid       (cmd_valid),
      .cmd_data        (cmd_data),
      .cmd_ready       (cmd_ready),
      .ctrl_q          (ctrl_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // One APB transfer; drives and samples on falling edges. pop_at >= 0
   // pulses cmd_ready during that wait cycle of the penable phase.
   task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_waits, input int pop_at);
      int waits;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(negedge clk);
      penable = 1'b1;
      waits = 0;
      while (!pready && waits < 100) begin
         @(negedge clk);
         waits++;
         if (pop_at >= 0) cmd_ready = (waits == pop_at);
      end
      if (pop_at >= 0) cmd_ready = 1'b0;
      chk({tag, "_rdy"},   32'(pready),  32'd1);
      chk({tag, "_waits"}, 32'(waits),   32'(exp_waits));
      chk({tag, "_err"},   32'(pslverr), 32'(exp_err));
      chk({tag, "_rd"},    prdata,       exp_rd);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic drain(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] exp [4];
      exp = '{w0, w1, w2, w3};
      @(negedge clk);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_vld"},  32'(cmd_valid), 32'd1);
         chk({tag, "_data"}, cmd_data,       exp[i]);
         @(negedge clk);
      end
      cmd_ready = 1'b0;
      chk({tag, "_empty"}, 32'(cmd_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; dbgen = 1'b1; niden = 1'b0; psel = 1'b0; penable = 1'b0;
      pwrite = 1'b0; paddr = '0; pwdata = '0; cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_prdata", prdata,            32'd0);
      chk("rst_pready", 32'(pready),       32'd0);
      chk("rst_slverr", 32'(pslverr),      32'd0);
      chk("rst_cvalid", 32'(cmd_valid),    32'd0);
      chk("rst_ctrl",   ctrl_q,            32'd0);
      rst = 1'b0;

      // Basic register access with debug enabled
      xfer("wr_scr", 1'b1, 12'h00C, 32'hA5A5_0001, 32'd0,          1'b0, 0, -1);
      xfer("rd_scr", 1'b0, 12'h00C, 32'd0,         32'hA5A5_0001, 1'b0, 0, -1);
      xfer("rd_id",  1'b0, 12'h000, 32'd0,         32'h0DB0_0100, 1'b0, 0, -1);

      // Non-invasive only: writes rejected, reads allowed
      dbgen = 1'b0; niden = 1'b1;
      xfer("wr_ctrl_gate", 1'b1, 12'h004, 32'h1, 32'd0, 1'b1, 0, -1);
      chk("ctrl_gate_q", ctrl_q, 32'd0);
      xfer("rd_stat_nid", 1'b0, 12'h008, 32'd0, 32'h0002_0002, 1'b0, 0, -1);

      // No enables: reads rejected with zero data
      niden = 1'b0;
      xfer("rd_scr_gate", 1'b0, 12'h00C, 32'd0, 32'd0, 1'b1, 0, -1);

      // RO write and unmapped accesses
      dbgen = 1'b1;
      xfer("wr_id",  1'b1, 12'h000, 32'h1234, 32'd0, 1'b1, 0, -1);
      xfer("rd_unm", 1'b0, 12'h018, 32'd0,    32'd0, 1'b1, 0, -1);
`ifdef DW_DBP_APB_ERRCNT_EN
      xfer("rd_ecnt",  1'b0, 12'h014, 32'd0, 32'd4, 1'b0, 0, -1);
      xfer("clr_ecnt", 1'b1, 12'h014, 32'd0, 32'd0, 1'b0, 0, -1);
      xfer("rd_ecnt0", 1'b0, 12'h014, 32'd0, 32'd0, 1'b0, 0, -1);
`else
      xfer("rd_ecnt_unm", 1'b0, 12'h014, 32'd0, 32'd0, 1'b1, 0, -1);
`endif

      // CTRL write with debug enabled
      xfer("wr_ctrl", 1'b1, 12'h004, 32'h0000_00C3, 32'd0, 1'b0, 0, -1);
      chk("ctrl_q", ctrl_q, 32'h0000_00C3);
      xfer("rd_ctrl", 1'b0, 12'h004, 32'd0, 32'h0000_00C3, 1'b0, 0, -1);

      // Fill FIFO with 1..4 while consumer is stalled, then drain
      for (int i = 1; i <= 4; i++)
         xfer("wr_data", 1'b1, 12'h010, 32'(i), 32'd0, 1'b0, 0, -1);
      xfer("rd_stat_full", 1'b0, 12'h008, 32'd0, 32'h0001_0401, 1'b0, 0, -1);
      xfer("rd_data",      1'b0, 12'h010, 32'd0, 32'd0,         1'b0, 0, -1);
      drain("drain1", 32'd1, 32'd2, 32'd3, 32'd4);

      // Refill, then full-FIFO write times out after 15 wait cycles
      for (int i = 1; i <= 4; i++)
         xfer("refill", 1'b1, 12'h010, 32'h10 + 32'(i), 32'd0, 1'b0, 0, -1);
      xfer("stall_to",   1'b1, 12'h010, 32'h55, 32'd0, 1'b1, 15, -1);
      xfer("stat_to",    1'b0, 12'h008, 32'd0, 32'h0001_0401, 1'b0, 0, -1);

      // Pop during stall cycle 3 frees a slot; push lands two cycles later
      xfer("stall_pop",  1'b1, 12'h010, 32'h77, 32'd0, 1'b0, 5, 3);
      xfer("stat_pop",   1'b0, 12'h008, 32'd0, 32'h0001_0401, 1'b0, 0, -1);
      drain("drain2", 32'h12, 32'h13, 32'h14, 32'h77);

      // Reset asserted while a DATA write is stalled
      for (int i = 1; i <= 4; i++)
         xfer("refill2", 1'b1, 12'h010, 32'(i), 32'd0, 1'b0, 0, -1);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h99;
      @(negedge clk);
      penable = 1'b1;
      repeat (3) @(negedge clk);
      chk("stall_hold", 32'(pready), 32'd0);
      chk("stall_vld",  32'(cmd_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_pready", 32'(pready),    32'd0);
      chk("mrst_cvalid", 32'(cmd_valid), 32'd0);
      chk("mrst_ctrl",   ctrl_q,         32'd0);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      xfer("mrst_stat", 1'b0, 12'h008, 32'd0, 32'h0002_0001, 1'b0, 0, -1);
      xfer("mrst_scr",  1'b0, 12'h00C, 32'd0, 32'd0,         1'b0, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
